// File: rtl/light_column_array_pkg.sv
// ============================================================================
// Module      : light_column_array_pkg
// Description : Shared defaults and index helpers for the arrow-light grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_column_array_pkg;

    localparam int DEF_NUM_COLS = 4;
    localparam int DEF_NUM_ROWS = 8;
    localparam int DEF_CNT_W    = 8;

    // The bottom row of a column is where key presses are judged.
    function automatic int hit_row(input int num_rows);
        return num_rows - 1;
    endfunction

    function automatic int light_idx(input int row, input int col, input int num_cols);
        return row * num_cols + col;
    endfunction

endpackage

`default_nettype wire

// File: rtl/light_column.sv
// ============================================================================
// Module      : light_column
// Description : One falling-light column: shift chain, key edge detect and
//               registered hit/miss judging on the bottom row.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_column
    import light_column_array_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step,
    input  logic                spawn,
    input  logic                key,
    input  logic                clear,
    output logic [NUM_ROWS-1:0] lights,
    output logic                hit,
    output logic                miss,
    output logic                judge
);

    localparam int BOT = hit_row(NUM_ROWS);

    logic key_q;
    logic press;

    assign press = key & ~key_q;
    // Combinational judge feeds the score adder in the same cycle.
    assign judge = press & lights[BOT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lights <= '0;
            key_q  <= 1'b0;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            key_q <= key;
            if (clear) begin
                lights <= '0;
                hit    <= 1'b0;
                miss   <= 1'b0;
            end else if (step) begin
                lights <= {lights[NUM_ROWS-2:0], spawn};
                hit    <= judge;
                miss   <= lights[BOT] & ~judge;
            end else begin
                // A hit light is consumed so it can neither be hit again nor miss.
                if (judge) begin
                    lights[BOT] <= 1'b0;
                end
                hit  <= judge;
                miss <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/light_column_array.sv
// ============================================================================
// Module      : light_column_array
// Description : NUM_COLS x NUM_ROWS falling-arrow grid with hit judging and a
//               saturating hit score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_column_array
    import light_column_array_pkg::*;
#(
    parameter int NUM_COLS = DEF_NUM_COLS,
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         STEP,
    input  logic [NUM_COLS-1:0]          SPAWN,
    input  logic [NUM_COLS-1:0]          KEY,
    input  logic                         CLEAR,
    output logic [NUM_ROWS*NUM_COLS-1:0] LIGHTS,
    output logic [NUM_COLS-1:0]          HIT,
    output logic [NUM_COLS-1:0]          MISS,
    output logic [CNT_W-1:0]             SCORE
);

    localparam int              PC_W      = $clog2(NUM_COLS + 1);
    localparam int              SUM_W     = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] SCORE_MAX = '1;

    logic [NUM_COLS-1:0] judge;
    logic [NUM_ROWS-1:0] col_lights [NUM_COLS];
    logic [PC_W-1:0]     hit_cnt;
    logic [SUM_W-1:0]    score_sum;
    logic [CNT_W-1:0]    score_next;

    generate
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            light_column #(
                .NUM_ROWS (NUM_ROWS)
            ) u_col (
                .clk    (CLOCK),
                .rst    (RESET),
                .step   (STEP),
                .spawn  (SPAWN[c]),
                .key    (KEY[c]),
                .clear  (CLEAR),
                .lights (col_lights[c]),
                .hit    (HIT[c]),
                .miss   (MISS[c]),
                .judge  (judge[c])
            );
            for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
                assign LIGHTS[light_idx(r, c, NUM_COLS)] = col_lights[c][r];
            end
        end
    endgenerate

    always_comb begin
        hit_cnt = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            hit_cnt = hit_cnt + PC_W'(judge[c]);
        end
        score_sum = SUM_W'(SCORE) + SUM_W'(hit_cnt);
        if (score_sum > SUM_W'(SCORE_MAX)) begin
            score_next = SCORE_MAX;
        end else begin
            score_next = score_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            SCORE <= '0;
        end else if (CLEAR) begin
            SCORE <= '0;
        end else begin
            SCORE <= score_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_light_column_array.sv
// ============================================================================
// Module      : tb_light_column_array
// Description : Vector-table bench for the arrow-light grid, with a 3-bit
//               score twin to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_light_column_array;

    logic        CLOCK;
    logic        RESET;
    logic        STEP;
    logic [3:0]  SPAWN;
    logic [3:0]  KEY;
    logic        CLEAR;
    logic [31:0] LIGHTS,   LIGHTS_S;
    logic [3:0]  HIT,      HIT_S;
    logic [3:0]  MISS,     MISS_S;
    logic [7:0]  SCORE;
    logic [2:0]  SCORE_S;

    light_column_array #(.NUM_COLS(4), .NUM_ROWS(8), .CNT_W(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .STEP(STEP), .SPAWN(SPAWN), .KEY(KEY),
        .CLEAR(CLEAR), .LIGHTS(LIGHTS), .HIT(HIT), .MISS(MISS), .SCORE(SCORE)
    );

    light_column_array #(.NUM_COLS(4), .NUM_ROWS(8), .CNT_W(3)) dut_sat (
        .CLOCK(CLOCK), .RESET(RESET), .STEP(STEP), .SPAWN(SPAWN), .KEY(KEY),
        .CLEAR(CLEAR), .LIGHTS(LIGHTS_S), .HIT(HIT_S), .MISS(MISS_S), .SCORE(SCORE_S)
    );

    typedef struct {
        logic        step;
        logic [3:0]  spawn;
        logic [3:0]  key;
        logic        clear;
        logic [31:0] lights;
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [7:0]  score;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [3:0] sp, input logic [3:0] k, input logic cl,
                       input logic [31:0] l, input logic [3:0] h, input logic [3:0] m, input logic [7:0] s);
        vec_t v;
        v.step = st; v.spawn = sp; v.key = k; v.clear = cl;
        v.lights = l; v.hit = h; v.miss = m; v.score = s;
        vecs.push_back(v);
    endtask

    // Fill one column pattern: first step spawns pat, then 7 empty steps.
    task automatic add_drop(input logic [3:0] pat, input logic [7:0] s);
        logic [31:0] p;
        p = {28'd0, pat};
        for (int k = 0; k < 8; k++) begin
            add(1'b1, (k == 0) ? pat : 4'b0000, 4'b0000, 1'b0, p << (4 * k), 4'b0000, 4'b0000, s);
        end
    endtask

    function automatic logic [31:0] sat3(input logic [7:0] s);
        return (s > 8'd7) ? 32'd7 : {24'd0, s};
    endfunction

    task automatic check_all(input string tag, input int idx, input vec_t e);
        check({tag, " LIGHTS"},    idx, LIGHTS,          e.lights);
        check({tag, " HIT"},       idx, {28'd0, HIT},    {28'd0, e.hit});
        check({tag, " MISS"},      idx, {28'd0, MISS},   {28'd0, e.miss});
        check({tag, " SCORE"},     idx, {24'd0, SCORE},  {24'd0, e.score});
        check({tag, " SCORE_SAT"}, idx, {29'd0, SCORE_S}, sat3(e.score));
    endtask

    initial begin
        vec_t e;
        vec_t z;
        z.step = 0; z.spawn = 0; z.key = 0; z.clear = 0;
        z.lights = 0; z.hit = 0; z.miss = 0; z.score = 0;

        // Fall-through miss on column 0.
        add_drop(4'b0001, 8'd0);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0001, 8'd0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd0);
        // Hit with STEP=0 on column 2, then hold the key.
        add_drop(4'b0100, 8'd0);
        add(1'b0, 4'b0000, 4'b0100, 1'b0, 32'h0000_0000, 4'b0100, 4'b0000, 8'd1);
        for (int k = 0; k < 10; k++) begin
            add(1'b0, 4'b0000, 4'b0100, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd1);
        end
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd1);
        // Hit on the same edge as STEP.
        add_drop(4'b0010, 8'd1);
        add(1'b1, 4'b0000, 4'b0010, 1'b0, 32'h0000_0000, 4'b0010, 4'b0000, 8'd2);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd2);
        // Early press on a dark column, then a two-column hit.
        add(1'b0, 4'b0000, 4'b1000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd2);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd2);
        add_drop(4'b1001, 8'd2);
        add(1'b0, 4'b0000, 4'b1001, 1'b0, 32'h0000_0000, 4'b1001, 4'b0000, 8'd4);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd4);
        // Saturation: clear, fill grid, then 4 + 4 + 1 hits.
        add(1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 4'b0000, 8'd0);
        for (int k = 0; k < 8; k++) begin
            add(1'b1, 4'b1111, 4'b0000, 1'b0, 32'((64'd1 << (4 * (k + 1))) - 64'd1), 4'b0000, 4'b0000, 8'd0);
        end
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 32'h0FFF_FFFF, 4'b1111, 4'b0000, 8'd4);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0FFF_FFFF, 4'b0000, 4'b0000, 8'd4);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 32'hFFFF_FFF0, 4'b0000, 4'b0000, 8'd4);
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 32'h0FFF_FFF0, 4'b1111, 4'b0000, 8'd8);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0FFF_FFF0, 4'b0000, 4'b0000, 8'd8);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 32'hFFFF_FF00, 4'b0000, 4'b0000, 8'd8);
        add(1'b0, 4'b0000, 4'b0001, 1'b0, 32'hEFFF_FF00, 4'b0001, 4'b0000, 8'd9);
        // CLEAR overrides a would-be hit on col 1 and a STEP with a lit hit row.
        add(1'b1, 4'b1111, 4'b0010, 1'b1, 32'h0000_0000, 4'b0000, 4'b0000, 8'd0);
        add(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 8'd0);
        // Refill and leave HIT pulsing for the mid-cycle reset.
        for (int k = 0; k < 8; k++) begin
            add(1'b1, 4'b1111, 4'b0000, 1'b0, 32'((64'd1 << (4 * (k + 1))) - 64'd1), 4'b0000, 4'b0000, 8'd0);
        end
        add(1'b0, 4'b0000, 4'b1111, 1'b0, 32'h0FFF_FFFF, 4'b1111, 4'b0000, 8'd4);

        RESET = 1'b1; STEP = 1'b0; SPAWN = 4'b0; KEY = 4'b0; CLEAR = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        check_all("reset", -1, z);
        RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            STEP = vecs[i].step; SPAWN = vecs[i].spawn; KEY = vecs[i].key; CLEAR = vecs[i].clear;
            sb.push_back(vecs[i]);
            @(posedge CLOCK);
            #1;
            e = sb.pop_front();
            check_all("vec", i, e);
        end

        // Asynchronous reset between edges, with the grid full and HIT high.
        #3;
        RESET = 1'b1;
        #1;
        check_all("async_reset", -2, z);
        KEY = 4'b0000;
        @(negedge CLOCK);
        RESET = 1'b0;
        @(posedge CLOCK);
        #1;
        check_all("post_reset", -3, z);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/light_column_array.md
Name: light_column_array

Overview:
- Parametrised successor of the single-light row cell: a complete NUM_COLS x NUM_ROWS grid of falling arrow lights for the DDR playfield.
- On each STEP tick, every column shifts down one row and a new top row is loaded from SPAWN.
- The bottom row is the hit zone: the block judges player key presses there, emits per-column HIT/MISS pulses and keeps a saturating hit score.
- Sits between the pattern generator (drives SPAWN/STEP) and the LED driver/score display.

Parameters:
- NUM_COLS, 4, number of arrow columns (>=1)
- NUM_ROWS, 8, rows per column including hit row (>=2)
- CNT_W, 8, width of the hit score counter

Ports:
- CLOCK  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- STEP  input  1  one-cycle tick: shift all columns down one row
- SPAWN  input  NUM_COLS  new top-row lights, sampled only when STEP=1
- KEY  input  NUM_COLS  player keys, level, already synchronised upstream
- CLEAR  input  1  synchronous flush of grid and score
- LIGHTS  output  NUM_ROWS*NUM_COLS  grid state; bit [r*NUM_COLS+c] = row r, column c; row 0 top, row NUM_ROWS-1 = hit row
- HIT  output  NUM_COLS  one-cycle pulse per column on successful hit
- MISS  output  NUM_COLS  one-cycle pulse per column when a lit hit-row light leaves unhit
- SCORE  output  CNT_W  saturating count of hits

Behaviour:
- Reset (async, RESET=1): LIGHTS=0, HIT=0, MISS=0, SCORE=0, key-edge registers=0; all takes effect immediately, mid-operation included. First update is on the first rising CLOCK after RESET falls.
- Key edge: press[c] = KEY[c] & ~key_q[c]; key_q <= KEY every cycle. A held key produces exactly one press.
- Hit judge (every cycle, per column c, evaluated on pre-edge state):
  - hit[c] = press[c] & LIGHTS[bottom,c].
  - A press with the hit row dark does nothing: no pulse, no penalty.
- Next state per column, priority CLEAR > STEP > hit:
  - CLEAR=1: whole grid cleared, SCORE=0. HIT, MISS and SCORE increment are all suppressed that cycle; key_q still updates.
  - STEP=1:
    - row0 <= SPAWN[c]; row r <= row r-1 for r>=1.
    - Old hit-row bit leaves the grid.
    - MISS[c] <= old hit-row bit & ~hit[c].
    - If hit[c], HIT[c] pulses and the departing light counts as hit, not miss.
  - STEP=0:
    - Rows hold.
    - If hit[c], the hit-row bit clears (light consumed) and HIT[c] <= 1.
  - A consumed light cannot be hit again or produce MISS.
- HIT and MISS are registered: the pulse is high exactly the cycle after the judging edge and 0 otherwise. HIT[c] and MISS[c] are never both 1.
- SCORE: adds popcount(hit) each non-CLEAR cycle. Saturates at 2^CNT_W-1; no wrap.
- STEP held high for consecutive cycles shifts every cycle; no internal rate limiting.
- SPAWN is ignored when STEP=0.

Decomposition:
- Shared constants header: default NUM_COLS/NUM_ROWS/CNT_W, hit-row index macro (NUM_ROWS-1), LIGHTS bit-index macro.
- One sub-module, light_column, instantiated NUM_COLS times via generate. It holds one column's NUM_ROWS shift chain, key edge register, hit/miss logic and registered HIT/MISS bits.
- The top level holds the popcount, saturating SCORE and LIGHTS packing.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill grid with SPAWN=4'b1111 for 8 STEPs, then assert RESET between clock edges.
  - Required: LIGHTS=0, SCORE=0, HIT=MISS=0 immediately, without waiting for a clock edge.
- Fall-through miss:
  - Stimulus: SPAWN=4'b0001 with one STEP, then 7 more STEPs with SPAWN=0.
  - Required: the light sits in row 7 col 0. On the 9th STEP, MISS=4'b0001 for one cycle; SCORE stays 0.
- Hit with STEP=0:
  - Stimulus: light in row 7 col 2, KEY[2] rises.
  - Required: next cycle HIT=4'b0100, hit-row bit cleared, SCORE=1. Holding KEY 10 more cycles gives no further HIT.
- Simultaneous hit and STEP:
  - Stimulus: light in row 7 col 1, KEY[1] rises the same cycle as STEP.
  - Required: HIT=4'b0010, MISS=0, SCORE +1.
- Early press and multi-column:
  - Stimulus: press KEY[3] with col 3 dark, then hit cols 0 and 3 in the same cycle.
  - Required: the first press gives no pulse. The second gives HIT=4'b1001 and SCORE +2.
- Saturation and CLEAR:
  - Stimulus: CNT_W=3, perform 9 hits.
  - Required: SCORE stops at 7. Then CLEAR=1 gives SCORE=0, LIGHTS=0, with no HIT/MISS pulse.
